alarm_set_ctrl: RTL
===================

Name: alarm_set_ctrl

Overview:
Button-driven alarm-time editor. It produces the BCD alarm time and the alarm-enable flag that the alarm sound controller consumes. It sits between the debounced front-panel buttons and the sound controller. It also drives the display digits and the field-blink flags used during editing.

Parameters:
REPEAT_DELAY, 500, clk cycles btn_inc must stay held before auto-repeat starts
REPEAT_PERIOD, 100, clk cycles between auto-repeat increments once repeating
EDIT_TIMEOUT, 5000, clk cycles with no press before an edit is abandoned

Ports:
clk  in  1  system clock, single domain
rst  in  1  asynchronous reset, active-high
btn_mode  in  1  debounced level, 1 = pressed
btn_inc  in  1  debounced level, 1 = pressed
hourdec_bud  out  4  committed alarm hour tens (0..2)
hourone_bud  out  4  committed alarm hour units (0..9, 0..3 when tens = 2)
mindec_bud  out  4  committed alarm minute tens (0..5)
minone_bud  out  4  committed alarm minute units (0..9)
bud_on  out  1  alarm armed
edit_hour  out  1  hour field being edited (display blink)
edit_min  out  1  minute field being edited (display blink)
disp_hourdec, disp_hourone, disp_mindec, disp_minone  out  4 each  shadow time while editing, committed time otherwise

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is asynchronous and active-high on rst.
  - rst = 1 gives: state IDLE, committed and shadow time 00:00, bud_on = 0, edit_hour = edit_min = 0, all counters 0, and button-history registers 0.
  - Reset asserted mid-edit discards the shadow immediately.
- Button press detection:
  - Each button has a registered previous level. press = level & ~prev.
  - This gives exactly one press per rising edge, one cycle after the edge is sampled.
  - An input that is held 1 at reset release does not produce a press.
- Auto-repeat (btn_inc only):
  - The hold counter counts from the press cycle while btn_inc stays 1.
  - After REPEAT_DELAY cycles an extra inc event fires, then one every REPEAT_PERIOD cycles.
  - Auto-repeat events are generated only in EDIT_HOUR and EDIT_MIN.
  - Release clears the hold counter.
- States:
  - IDLE:
    - inc press toggles bud_on.
    - mode press copies committed time into the shadow and moves to EDIT_HOUR.
  - EDIT_HOUR:
    - inc event increments the shadow hour.
    - mode press moves to EDIT_MIN.
  - EDIT_MIN:
    - inc event increments the shadow minute.
    - mode press commits the shadow to the *_bud outputs, sets bud_on = 1, and returns to IDLE.
- Outputs and timing:
  - Outputs are registered. A commit is visible on *_bud the cycle after the mode press is detected.
  - edit_hour = 1 only in EDIT_HOUR; edit_min = 1 only in EDIT_MIN.
- Hour increment (BCD):
  - 23 wraps to 00.
  - Units 9 gives tens+1, units 0.
  - Otherwise units+1.
- Minute increment (BCD):
  - Units 9 gives units 0; tens 5 then wraps to 0, else tens+1. So 59 wraps to 00.
  - Minute wrap does not carry into the hour.
- Timeout:
  - The idle counter restarts on every press or auto-repeat event and counts only in edit states.
  - On reaching EDIT_TIMEOUT: return to IDLE with no commit; *_bud and bud_on are unchanged.
- Simultaneous events:
  - mode and inc pressed in the same cycle: mode wins and inc is ignored for that cycle.
  - A mode press in the same cycle the timeout expires: mode wins.
- The committed time is always a legal BCD time. The shadow never holds an illegal value.

Decomposition:
- Package alarm_pkg:
  - enum alarm_state_t {IDLE, EDIT_HOUR, EDIT_MIN}.
  - BCD limit constants: HOUR_MAX_DEC = 2, HOUR_MAX_ONE_AT_2 = 3, MIN_MAX_DEC = 5, DIGIT_MAX = 9.
  - bcd_time_t struct of four 4-bit digits.
- One sub-module, alarm_btn_repeat:
  - Does the edge detect, hold counter and repeat pulse generation.
  - Has an enable input.
  - Instantiated for btn_inc. btn_mode uses only an inline edge detect.

Test Plan:
- Reset with rst = 1 mid-edit, then release: *_bud = 0,0,0,0, bud_on = 0, edit flags 0, and the display shows 00:00.
- In IDLE, pulse inc twice: bud_on goes 0 → 1 → 0. *_bud is unchanged.
- Press mode; press inc 24 times; press mode; press inc 61 times; press mode:
  - shadow hour sequence passes 09 → 10, 19 → 20, and 23 → 00;
  - final commit is 00:01 with bud_on = 1.
- In EDIT_MIN, hold btn_inc for REPEAT_DELAY + 3·REPEAT_PERIOD + 1 cycles from 00:
  - shadow minute = 04 (1 press + 3 repeats);
  - no repeats occur in IDLE under the same hold.
- Enter edit, set hour to 07, then idle for EDIT_TIMEOUT cycles:
  - state returns to IDLE;
  - *_bud keeps the previous value;
  - the display shows committed time.
- Raise btn_mode and btn_inc in the same cycle while in EDIT_HOUR: state moves to EDIT_MIN and the shadow hour is unchanged.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types, BCD limits and digit-increment helpers for the alarm-time editor.
package alarm_pkg;

  typedef enum logic [1:0] {IDLE, EDIT_HOUR, EDIT_MIN} alarm_state_t;

  localparam logic [3:0] HOUR_MAX_DEC      = 4'd2;
  localparam logic [3:0] HOUR_MAX_ONE_AT_2 = 4'd3;
  localparam logic [3:0] MIN_MAX_DEC       = 4'd5;
  localparam logic [3:0] DIGIT_MAX         = 4'd9;

  typedef struct packed {
    logic [3:0] hdec;
    logic [3:0] hone;
    logic [3:0] mdec;
    logic [3:0] mone;
  } bcd_time_t;

  function automatic bcd_time_t inc_hour(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.hdec == HOUR_MAX_DEC && t.hone == HOUR_MAX_ONE_AT_2) begin
      r.hdec = 4'd0;
      r.hone = 4'd0;
    end else if (t.hone == DIGIT_MAX) begin
      r.hdec = t.hdec + 4'd1;
      r.hone = 4'd0;
    end else begin
      r.hone = t.hone + 4'd1;
    end
    return r;
  endfunction

  // Minute wrap deliberately leaves the hour digits alone.
  function automatic bcd_time_t inc_min(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.mone == DIGIT_MAX) begin
      r.mone = 4'd0;
      r.mdec = (t.mdec == MIN_MAX_DEC) ? 4'd0 : t.mdec + 4'd1;
    end else begin
      r.mone = t.mone + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alarm_btn_repeat.sv
// Rising-edge press detect plus hold-to-repeat pulse generator for one button.
module alarm_btn_repeat #(
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  input  logic en_i,
  output logic press_o,
  output logic rep_o
);

  // cnt_q is 0 when not in a held press, else cycles since the press (press cycle = 0 -> 1).
  localparam int CW = $clog2(REPEAT_DELAY + 2);
  localparam logic [CW-1:0] FIRE_AT = CW'(REPEAT_DELAY + 1);
  localparam logic [CW-1:0] RELOAD  = CW'(REPEAT_DELAY + 2 - REPEAT_PERIOD);

  logic          prev_q, arm_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fire;

  // arm_q blocks a press from a level already high when reset is released.
  assign press_o = btn_i & ~prev_q & arm_q;
  assign fire    = btn_i & (cnt_q == FIRE_AT);
  assign rep_o   = fire & en_i;

  always_comb begin
    cnt_d = '0;
    if (btn_i) begin
      if (press_o)           cnt_d = CW'(1);
      else if (fire)         cnt_d = RELOAD;
      else if (cnt_q != '0)  cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      arm_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= btn_i;
      arm_q  <= arm_q | ~btn_i;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/alarm_set_ctrl.sv
// Button-driven alarm-time editor: edits a shadow time and commits it to the
// alarm sound controller, with auto-repeat on inc and an inactivity timeout.
module alarm_set_ctrl
  import alarm_pkg::*;
#(
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100,
  parameter int EDIT_TIMEOUT  = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hourdec_bud,
  output logic [3:0] hourone_bud,
  output logic [3:0] mindec_bud,
  output logic [3:0] minone_bud,
  output logic       bud_on,
  output logic       edit_hour,
  output logic       edit_min,
  output logic [3:0] disp_hourdec,
  output logic [3:0] disp_hourone,
  output logic [3:0] disp_mindec,
  output logic [3:0] disp_minone
);

  localparam int TW = $clog2(EDIT_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(EDIT_TIMEOUT - 1);

  alarm_state_t st_q, st_d;
  bcd_time_t    sh_q, sh_d, cm_q, cm_d, disp_q, disp_d;
  logic         on_q, on_d, eh_q, em_q;
  logic [TW-1:0] tmo_q, tmo_d;
  logic         mprev_q, marm_q, mode_press;
  logic         inc_press, inc_rep, inc_evt;

  assign mode_press = btn_mode & ~mprev_q & marm_q;
  assign inc_evt    = inc_press | inc_rep;

  alarm_btn_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_inc (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_inc),
    .en_i   (st_q != IDLE),
    .press_o(inc_press),
    .rep_o  (inc_rep)
  );

  // Priority in edit states: mode press, then inc event, then timeout.
  always_comb begin
    st_d  = st_q;
    sh_d  = sh_q;
    cm_d  = cm_q;
    on_d  = on_q;
    tmo_d = '0;
    case (st_q)
      IDLE: begin
        if (mode_press) begin
          sh_d = cm_q;
          st_d = EDIT_HOUR;
        end else if (inc_press) begin
          on_d = ~on_q;
        end
      end
      EDIT_HOUR, EDIT_MIN: begin
        if (mode_press) begin
          if (st_q == EDIT_HOUR) begin
            st_d = EDIT_MIN;
          end else begin
            cm_d = sh_q;
            on_d = 1'b1;
            st_d = IDLE;
          end
        end else if (inc_evt) begin
          sh_d = (st_q == EDIT_HOUR) ? inc_hour(sh_q) : inc_min(sh_q);
        end else if (tmo_q == TMO_LAST) begin
          st_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: st_d = IDLE;
    endcase
    disp_d = (st_d == IDLE) ? cm_d : sh_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= IDLE;
      sh_q    <= '0;
      cm_q    <= '0;
      disp_q  <= '0;
      on_q    <= 1'b0;
      eh_q    <= 1'b0;
      em_q    <= 1'b0;
      tmo_q   <= '0;
      mprev_q <= 1'b0;
      marm_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      sh_q    <= sh_d;
      cm_q    <= cm_d;
      disp_q  <= disp_d;
      on_q    <= on_d;
      eh_q    <= (st_d == EDIT_HOUR);
      em_q    <= (st_d == EDIT_MIN);
      tmo_q   <= tmo_d;
      mprev_q <= btn_mode;
      marm_q  <= marm_q | ~btn_mode;
    end
  end

  assign hourdec_bud  = cm_q.hdec;
  assign hourone_bud  = cm_q.hone;
  assign mindec_bud   = cm_q.mdec;
  assign minone_bud   = cm_q.mone;
  assign bud_on       = on_q;
  assign edit_hour    = eh_q;
  assign edit_min     = em_q;
  assign disp_hourdec = disp_q.hdec;
  assign disp_hourone = disp_q.hone;
  assign disp_mindec  = disp_q.mdec;
  assign disp_minone  = disp_q.mone;

endmodule
